// File: rtl/bcd_dec.sv
// bcd_dec: sequential BCD-to-binary converter (reverse double-dabble).
// One bit of the binary result is produced per clock over BIN_W cycles.
module bcd_dec #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [SR_W-1:0]    r_sr, w_sr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_err_pend, w_err_pend_nxt;
    logic [BIN_W-1:0]   r_bin, w_bin_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;

    logic [SR_W-1:0]    w_shift;
    logic [SR_W-1:0]    w_adj;
    logic               w_bad;

    // Shift right, then pull every BCD digit >= 8 back down by 3.
    always_comb begin
        w_shift = {1'b0, r_sr[SR_W-1:1]};
        w_adj   = w_shift;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_shift[BIN_W+4*d +: 4] >= 4'd8) begin
                w_adj[BIN_W+4*d +: 4] = w_shift[BIN_W+4*d +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        w_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sr_nxt       = r_sr;
        w_cnt_nxt      = r_cnt;
        w_err_pend_nxt = r_err_pend;
        w_bin_nxt      = r_bin;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sr_nxt       = {bcd, {BIN_W{1'b0}}};
                    w_cnt_nxt      = '0;
                    w_err_pend_nxt = w_bad;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sr_nxt  = w_adj;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_bin_nxt   = r_err_pend ? '0 : w_adj[BIN_W-1:0];
                    w_err_nxt   = r_err_pend;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            r_bin      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err_pend <= w_err_pend_nxt;
            r_bin      <= w_bin_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bin  = r_bin;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: doc/bcd_dec.md
# bcd_dec

Sequential BCD-to-binary converter: the inverse of the binary-to-BCD path. It accepts a packed DIGITS-digit BCD value on a start strobe. It runs a reverse double-dabble (shift right, then subtract 3 from every digit ≥ 8) over BIN_W clock cycles. It returns the binary result with a one-cycle done pulse. It sits between BCD-entry logic (keypad/switch digits) and arithmetic datapaths that operate on plain binary.

## Interface
- DIGITS, default 3: number of packed BCD digits on the input.
- BIN_W, default 10: binary result width; must satisfy 2^BIN_W > 10^DIGITS − 1 (3 digits → 10 bits).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- bcd  in  4*DIGITS  packed BCD, digit 0 in bits [3:0]; sampled only on the accepted start edge.
- bin  out  BIN_W  binary result; registered, held until the next result is written.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse: bin/err valid.
- err  out  1  any input digit > 9 on the last accepted request; held with bin.

## Operation
- One clock, rst asynchronous active-high; all outputs registered.
- Reset values: bin=0, busy=0, done=0, err=0, state=IDLE, shift register=0, count=0.
- Shift register holds {bcd_part[4*DIGITS-1:0], bin_part[BIN_W-1:0]}.
- FSM states:
  - IDLE: if start=1, load bcd_part←bcd, bin_part←0, count←0, err_pending←(any digit > 9), busy←1, go SHIFT. Otherwise stay.
  - SHIFT: each cycle, shift the whole register right by 1 (bcd_part LSB enters bin_part MSB, 0 enters bcd_part MSB). Then, for every digit of the shifted bcd_part independently, if digit ≥ 8, subtract 3 (4-bit, no carry between digits). count←count+1. On the cycle performing shift number BIN_W (count=BIN_W−1): bin←(err_pending ? 0 : shifted bin_part), err←err_pending, busy←0, done←1, go DONE.
  - DONE: done←0, go IDLE. start is ignored in this state.
- Invalid digits do not abort the conversion; the full BIN_W cycles run and bin is forced to 0 with err=1.
- bcd changes after the accepted start edge have no effect.
- start while busy or in DONE is ignored; nothing is queued.
- After a full conversion, bcd_part is zero for any valid input (maximum value < 2^BIN_W).

## Timing
- start sampled high at rising edge k in IDLE → busy=1 after edge k.
- Shifts occur on edges k+1 … k+BIN_W.
- Edge k+BIN_W updates bin and err, deasserts busy, and asserts done.
- done is high for exactly the one cycle between edges k+BIN_W and k+BIN_W+1.
- Latency with the defaults: 10 cycles from the start edge to done; throughput is one conversion per BIN_W+2 cycles.
- Earliest next accepted start is edge k+BIN_W+2 (IDLE reached at k+BIN_W+1).
- bin and err hold stable from the done edge until the next conversion's done edge. They do not clear on start.
- rst asserted at any point, including mid-SHIFT or during DONE, immediately forces all reset values. No done pulse is produced for the aborted conversion.
- rst deassert: the first start can be accepted on the first rising edge with rst low.

## Test plan
- After reset, start with bcd=12'h000 → done 10 cycles after the start edge; bin=0, err=0, busy high for exactly cycles k+1..k+10.
- bcd=12'h255 → bin=10'd255; bcd=12'h999 → bin=10'd999 (10'h3E7); bcd=12'h010 → bin=10'd10; err=0 in each case.
- bcd=12'h1A3 (digit 1 = 0xA) → full 10-cycle run, then done=1, err=1, bin=0. A following bcd=12'h042 → bin=42, err=0.
- start=1 held continuously with bcd=12'h123, bcd changed to 12'h456 at edge k+3 → one done per 12 cycles; every result is 123 from its own accepted edge, or 456 once bcd changed before an accept edge; no extra done pulses.
- rst pulsed at edge k+5 of a conversion of 12'h777 → bin, busy, done, err all 0 immediately; no done appears. A new start with 12'h500 yields bin=500 after 10 cycles.
- Exhaustive sweep of all valid values 000..999, back-to-back, checked against a decimal model → every bin matches, err=0, exactly one done per request.
